// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath.
// - sc_state_e      : decoder control states
// - sc_window_len   : window length (2^width valid bits)
// - sc_result_width : binary result width (width+1), shared with the bitstream generators
package sc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StHold
  } sc_state_e;

  function automatic int unsigned sc_window_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

  // One extra bit so a window of all ones (2^width) is representable.
  function automatic int unsigned sc_result_width(input int unsigned width);
    return width + 32'd1;
  endfunction

endpackage

// File: rtl/sc_stream_decoder_if.sv
// Stream decoder bus: conversion request, bitstream input and result handshake.
// - master : bitstream producer / result consumer side
// - slave  : decoder side
interface sc_stream_decoder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             busy;
  logic [WIDTH:0]   result;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output start,
    output bit_in,
    output bit_valid,
    output result_ready,
    input  busy,
    input  result,
    input  result_valid
  );

  modport slave (
    input  start,
    input  bit_in,
    input  bit_valid,
    input  result_ready,
    output busy,
    output result,
    output result_valid
  );

endinterface

// File: rtl/sc_window_counter.sv
// Sample and ones counters for one conversion window.
// Ports:
// - clk, rst : clock, synchronous active-high reset
// - clear    : zero both counters (new window)
// - enable   : consume bit_in this cycle
// - bit_in   : stochastic sample
// - total    : ones counted so far plus the current bit_in
// - last     : current sample is the final one of the window
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           enable,
  input  logic           bit_in,
  output logic [WIDTH:0] total,
  output logic           last
);

  localparam int unsigned WinLen = sc_window_len(WIDTH);
  localparam int unsigned ResW   = sc_result_width(WIDTH);

  logic [WIDTH-1:0] sample_q;
  logic [ResW-1:0]  ones_q;

  // sample_q wraps to zero on the terminal sample; the next start clears it anyway.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_q <= '0;
      ones_q   <= '0;
    end else if (enable) begin
      sample_q <= sample_q + WIDTH'(1);
      ones_q   <= total;
    end
  end

  assign total = ones_q + ResW'(bit_in);
  assign last  = (sample_q == WIDTH'(WinLen - 1));

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream to binary decoder: counts ones over a window of 2^WIDTH
// valid samples and presents the count on a valid/ready handshake.
// Ports:
// - clk, rst : clock, synchronous active-high reset
// - bus      : slave side of sc_stream_decoder_if (start, bit_in, bit_valid,
//              busy, result, result_valid, result_ready)
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  sc_stream_decoder_if.slave  bus
);

  sc_state_e      state_q, state_d;
  logic [WIDTH:0] result_q, result_d;
  logic           result_valid_q, result_valid_d;
  logic           cnt_clear;
  logic           cnt_enable;
  logic [WIDTH:0] cnt_total;
  logic           cnt_last;

  sc_window_counter #(
    .WIDTH (WIDTH)
  ) u_window_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .bit_in (bus.bit_in),
    .total  (cnt_total),
    .last   (cnt_last)
  );

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    cnt_clear      = 1'b0;
    cnt_enable     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_clear = 1'b1;
          state_d   = StCount;
        end
      end
      StCount: begin
        cnt_enable = bus.bit_valid;
        if (bus.bit_valid && cnt_last) begin
          result_d       = cnt_total;
          result_valid_d = 1'b1;
          state_d        = StHold;
        end
      end
      StHold: begin
        if (bus.result_ready) begin
          result_valid_d = 1'b0;
          if (bus.start) begin
            cnt_clear = 1'b1;
            state_d   = StCount;
          end else begin
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.busy         = (state_q == StCount);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
module tb_sc_stream_decoder;

  localparam int unsigned W   = 4;
  localparam int unsigned WIN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sc_stream_decoder_if #(.WIDTH(W)) bus ();

  sc_stream_decoder #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 counting, 2 holding; window is the list of accepted bits.
  int          m_mode = 0;
  int          m_win[$];
  int unsigned m_res  = 0;
  bit          m_rv   = 1'b0;

  task automatic chk_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned win_ones();
    int unsigned s = 0;
    foreach (m_win[i]) s += m_win[i];
    return s;
  endfunction

  task automatic model_update(input bit r, input bit s, input bit b, input bit v, input bit rdy);
    if (r) begin
      m_mode = 0;
      m_win.delete();
      m_rv   = 1'b0;
      m_res  = 0;
    end else if (m_mode == 0) begin
      if (s) begin
        m_win.delete();
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (v) begin
        m_win.push_back(int'(b));
        if (m_win.size() == WIN) begin
          m_res  = win_ones();
          m_rv   = 1'b1;
          m_mode = 2;
        end
      end
    end else begin
      if (rdy) begin
        m_rv = 1'b0;
        if (s) begin
          m_win.delete();
          m_mode = 1;
        end else begin
          m_mode = 0;
        end
      end
    end
  endtask

  // Apply inputs for one cycle, advance the model on the edge, then compare.
  task automatic step(input bit r, input bit s, input bit b, input bit v, input bit rdy);
    rst              = r;
    bus.start        = s;
    bus.bit_in       = b;
    bus.bit_valid    = v;
    bus.result_ready = rdy;
    @(posedge clk);
    model_update(r, s, b, v, rdy);
    #1;
    chk_eq("busy", int'(bus.busy), int'(m_mode == 1));
    chk_eq("result_valid", int'(bus.result_valid), int'(m_rv));
    chk_eq("result", int'(bus.result), m_res);
  endtask

  int busy_cnt;

  initial begin
    bus.start = 1'b0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.result_ready = 1'b0;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    chk_eq("reset_busy", int'(bus.busy), 0);
    chk_eq("reset_result", int'(bus.result), 0);

    // 1: 16 continuous ones; busy exactly 16 cycles, valid 1 cycle after last bit
    busy_cnt = 0;
    step(0, 1, 1, 1, 0);
    busy_cnt += int'(bus.busy);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 1, 0);
      busy_cnt += int'(bus.busy);
      if (i == 15) chk_eq("t1_valid_after_last", int'(bus.result_valid), 1);
    end
    step(0, 0, 0, 0, 0);
    busy_cnt += int'(bus.busy);
    chk_eq("t1_busy_cycles", busy_cnt, 16);
    chk_eq("t1_result", int'(bus.result), 16);
    step(0, 0, 0, 0, 1);

    // 2: alternating bits with bit_valid toggling; stall cycles carry junk ones
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) step(0, 0, bit'((i / 2) % 2 == 0), 1, 0);
      else            step(0, 0, 1, 0, 0);
    end
    chk_eq("t2_result_alt", int'(bus.result), 8);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
    chk_eq("t2_result_zero", int'(bus.result), 0);
    step(0, 0, 0, 0, 1);

    // 3: result 5, held while ready low with start/bit_in toggling
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, bit'(i < 5), 1, 0);
    for (int i = 0; i < 6; i++) step(0, bit'(i % 2), bit'(i % 2 == 0), 1, 0);
    chk_eq("t3_held_result", int'(bus.result), 5);
    step(0, 0, 0, 0, 1);
    chk_eq("t3_release_valid", int'(bus.result_valid), 0);
    chk_eq("t3_release_busy", int'(bus.busy), 0);

    // 4: back-to-back ready+start; the HOLD-cycle bit must not be counted
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, bit'(i % 3 == 0), 1, 0);
    step(0, 1, 1, 1, 1);
    chk_eq("t4_b2b_busy", int'(bus.busy), 1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 0);
    chk_eq("t4_result", int'(bus.result), 16);
    step(0, 0, 0, 0, 1);

    // 5: reset mid-window, then an all-zero window
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    chk_eq("t5_rst_result", int'(bus.result), 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
    chk_eq("t5_result", int'(bus.result), 0);
    step(0, 0, 0, 0, 1);

    // 6: start during COUNT does not restart
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, bit'(i == 8), 1, 1, 0);
    chk_eq("t6_result", int'(bus.result), 16);
    chk_eq("t6_valid", int'(bus.result_valid), 1);
    step(0, 0, 0, 0, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 199) == 0),
           bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Converts a unipolar stochastic bitstream, such as toggle/flip-flop generated streams feeding the MAC, back into a binary value.
- Counts the ones in a fixed window of 2^WIDTH valid bits.
- Presents the count on a valid/ready output handshake.
- Sits at the output end of the stochastic datapath, between the bitstream producers and the binary result bus.

Parameters:
- WIDTH, 8, log2 of window length; window is 2^WIDTH valid bits; result is WIDTH+1 bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a new conversion window; accepted only in IDLE, or in HOLD on the handshake cycle.
- bit_in  input  1  stochastic bitstream sample.
- bit_valid  input  1  bit_in is a valid sample this cycle; low means stall, no sample consumed.
- busy  output  1  high in COUNT state.
- result  output  WIDTH+1  number of ones in the window, 0..2^WIDTH.
- result_valid  output  1  result is held and stable.
- result_ready  input  1  consumer accepts result.

Behaviour:
- Reset: state=IDLE, busy=0, result_valid=0, result=0; internal sample counter and ones counter=0. Reset during any state aborts the window; partial counts are discarded.
- States: IDLE, COUNT, HOLD.
- IDLE:
  - start=1: clear both counters, go to COUNT next cycle.
  - bit_in/bit_valid ignored in IDLE, including on the start cycle.
- COUNT:
  - Each cycle with bit_valid=1: sample_cnt increments; ones_cnt increments if bit_in=1.
  - sample_cnt is WIDTH bits.
  - Terminal condition: bit_valid=1 and sample_cnt==2^WIDTH-1. Next cycle:
    - result = ones_cnt plus current bit_in, WIDTH+1 bits, no saturation;
    - result_valid=1; busy=0; state=HOLD.
  - Latency: result_valid rises exactly 1 cycle after the last accepted bit.
  - start in COUNT is ignored and does not restart.
  - bit_valid=0 holds all counters.
- HOLD:
  - result and result_valid held stable until result_ready=1.
  - result_ready=1 and start=0: result_valid=0 next cycle, state=IDLE; result keeps its last value.
  - result_ready=1 and start=1: back-to-back; result_valid=0, counters cleared, state=COUNT next cycle.
  - start without result_ready in HOLD is ignored.
  - bit_in is ignored in HOLD; producers must stall.
- Arithmetic: ones_cnt is WIDTH+1 bits, so a full window of 2^WIDTH ones is representable. sample_cnt wraps to 0 at the terminal sample; this is harmless because the counter is cleared on the next start.
- Only one window is in flight at a time. No overflow or underflow states exist beyond those above.

Decomposition:
- Package sc_pkg holds:
  - state enum {IDLE, COUNT, HOLD};
  - function/constant for window length 2^WIDTH;
  - shared result-width helper WIDTH+1, reused by the bitstream generators.
- Sub-module sc_window_counter:
  - sample counter plus ones counter with clear, enable and terminal flag;
  - instantiated once.
- FSM and output registers live in the top.

Test Plan (WIDTH=4, window 16):
1. rst, start, 16 bits of 1 with bit_valid=1 continuous -> result_valid rises 1 cycle after the 16th bit; result=16; busy high for exactly 16 cycles.
2. start, 16 alternating bits 1,0,... with bit_valid toggling every other cycle (32 cycles) -> result=8; counters frozen on bit_valid=0 cycles; all-zero window -> result=0.
3. Complete a window with result=5; hold result_ready=0 for 6 cycles with bit_in/start toggling -> result and result_valid unchanged; result_ready=1 -> result_valid=0 next cycle, state IDLE.
4. result_ready=1 and start=1 in the same HOLD cycle; next window of 16 ones -> back-to-back COUNT; second result=16; no bits lost or counted from the HOLD cycle.
5. start, 7 ones accepted, assert rst 1 cycle -> busy=0, result_valid=0, result=0. Then start plus 16 zeros -> result=0, with no leftover count.
6. start asserted again at bit 9 during COUNT with 16 ones total -> no restart; result=16 after the 16th bit.
